// File: rtl/sprite_row_scheduler.sv
// Per-scanline sprite scheduler: scans OAM in index order, fetches pattern rows for sprites
// covering the target row and offers them to the sprite-unit chain via a valid/ack handshake.
module sprite_row_scheduler #(
  parameter int unsigned NUM_SPRITES = 64,
  parameter int unsigned NUM_UNITS   = 16,
  parameter int unsigned PAT_W       = 32,
  parameter int unsigned CONF_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [7:0]                       row_i,
  output logic [$clog2(NUM_SPRITES)-1:0]   oam_addr_o,
  input  logic [7:0]                       oam_y_i,
  input  logic [1:0]                       oam_h_i,
  input  logic                             oam_y_mirror_i,
  input  logic [CONF_W-1:0]                oam_conf_i,
  output logic [$clog2(NUM_SPRITES)+4:0]   pat_addr_o,
  input  logic [PAT_W*4-1:0]               pat_rdata_i,
  output logic                             chain_clear_o,
  // Packed sprite entry: {conf, pattern row}
  output logic [CONF_W+PAT_W*4-1:0]        out_o,
  output logic                             out_valid_o,
  input  logic                             out_ack_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);

  localparam int unsigned IdxW = $clog2(NUM_SPRITES);
  localparam int unsigned CntW = $clog2(NUM_UNITS + 1);
  localparam int unsigned OutW = CONF_W + PAT_W * 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StOamRd  = 3'd2;
  localparam logic [2:0] StOamChk = 3'd3;
  localparam logic [2:0] StPatRd  = 3'd4;
  localparam logic [2:0] StPush   = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [OutW-1:0]   out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [IdxW+4:0]   pat_addr_q, pat_addr_d;

  logic [2:0] hp1;
  logic [8:0] row9, top9, height9, bot9;
  logic       hit, last;
  logic [4:0] r_raw, r_mir, r_sel;

  // Hit window compared in 9 bits so a sprite near row 255 never wraps to row 0.
  always_comb begin
    hp1     = {1'b0, oam_h_i} + 3'd1;
    row9    = {1'b0, row_q};
    top9    = {1'b0, oam_y_i};
    height9 = {3'b000, hp1, 3'b000};
    bot9    = top9 + height9;
    hit     = (row9 >= top9) && (row9 < bot9);
    r_raw   = row_q[4:0] - oam_y_i[4:0];
    r_mir   = {hp1[1:0], 3'b000} - 5'd1 - r_raw;
    r_sel   = oam_y_mirror_i ? r_mir : r_raw;
    last    = (idx_q == IdxW'(NUM_SPRITES - 1));
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    conf_d      = conf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pat_addr_d  = pat_addr_q;
    if (start_i) begin
      // Start from any state (including mid-row) restarts the row from scratch.
      row_d       = row_i;
      idx_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = StClear;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StClear: state_d = StOamRd;
        StOamRd: state_d = StOamChk;
        StOamChk: begin
          if (hit) begin
            if (cnt_q == CntW'(NUM_UNITS)) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              pat_addr_d = {idx_q, r_sel};
              conf_d     = oam_conf_i;
              state_d    = StPatRd;
            end
          end else if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StOamRd;
          end
        end
        StPatRd: begin
          out_d       = {conf_q, pat_rdata_i};
          out_valid_d = 1'b1;
          state_d     = StPush;
        end
        StPush: begin
          if (out_ack_i) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
            if (last) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StOamRd;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      row_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      conf_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pat_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      conf_q      <= conf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pat_addr_q  <= pat_addr_d;
    end
  end

  // pat_addr is presented in the check cycle itself so the RAM data lands in the fetch cycle.
  always_comb begin
    oam_addr_o    = idx_q;
    pat_addr_o    = pat_addr_d;
    chain_clear_o = (state_q == StClear);
    out_o         = out_q;
    out_valid_o   = out_valid_q;
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    overflow_o    = ovf_q;
  end

endmodule

// File: tb/tb_sprite_row_scheduler.sv
// Directed bench for sprite_row_scheduler with behavioural OAM and pattern RAMs (1-cycle latency).
module tb_sprite_row_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [7:0]   row_i = '0;
  logic [5:0]   oam_addr_o;
  logic [7:0]   oam_y_i = '0;
  logic [1:0]   oam_h_i = '0;
  logic         oam_y_mirror_i = 1'b0;
  logic [15:0]  oam_conf_i = '0;
  logic [10:0]  pat_addr_o;
  logic [127:0] pat_rdata_i = '0;
  logic         chain_clear_o;
  logic [143:0] out_o;
  logic         out_valid_o;
  logic         out_ack_i = 1'b1;
  logic         busy_o, done_o, overflow_o;

  sprite_row_scheduler dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .row_i          (row_i),
    .oam_addr_o     (oam_addr_o),
    .oam_y_i        (oam_y_i),
    .oam_h_i        (oam_h_i),
    .oam_y_mirror_i (oam_y_mirror_i),
    .oam_conf_i     (oam_conf_i),
    .pat_addr_o     (pat_addr_o),
    .pat_rdata_i    (pat_rdata_i),
    .chain_clear_o  (chain_clear_o),
    .out_o          (out_o),
    .out_valid_o    (out_valid_o),
    .out_ack_i      (out_ack_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] y_m   [64];
  logic [1:0] h_m   [64];
  logic       mir_m [64];

  always @(posedge clk_i) begin
    oam_y_i        <= y_m[oam_addr_o];
    oam_h_i        <= h_m[oam_addr_o];
    oam_y_mirror_i <= mir_m[oam_addr_o];
    oam_conf_i     <= 16'hC000 | 16'(oam_addr_o);
    pat_rdata_i    <= 128'(pat_addr_o) | (128'hC0DE << 64);
  end

  // Monitor: monotonic event counts and a log of accepted pushes.
  int unsigned  clr_cnt = 0, done_cnt = 0, valid_cnt = 0;
  logic [143:0] pushes [$];
  logic [10:0]  pa_log [$];

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (chain_clear_o) clr_cnt++;
      if (done_o) done_cnt++;
      if (out_valid_o) valid_cnt++;
      if (out_valid_o && out_ack_i) begin
        pushes.push_back(out_o);
        pa_log.push_back(pat_addr_o);
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] exp_out(input int i, input logic [10:0] a);
    return {16'hC000 | 16'(i), 128'(a) | (128'hC0DE << 64)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all_miss();
    for (int i = 0; i < 64; i++) begin
      y_m[i] = 8'd200; h_m[i] = 2'd0; mir_m[i] = 1'b0;
    end
  endtask

  task automatic do_start(input logic [7:0] r);
    row_i = r; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Returns cycles from start edge to the done cycle (start edge counts as 1).
  task automatic wait_done(input int limit, output int n);
    n = 1;
    while (!done_o && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, out_o, '0);
    chk({tag, "_valid"}, 144'(out_valid_o), '0);
    chk({tag, "_oam_addr"}, 144'(oam_addr_o), '0);
    chk({tag, "_pat_addr"}, 144'(pat_addr_o), '0);
    chk({tag, "_busy"}, 144'(busy_o), '0);
    chk({tag, "_done"}, 144'(done_o), '0);
    chk({tag, "_ovf"}, 144'(overflow_o), '0);
    chk({tag, "_clear"}, 144'(chain_clear_o), '0);
  endtask

  initial begin
    int n, base, c0, v0, d0, k;
    set_all_miss();
    repeat (3) tick();
    chk_zero("reset");
    rst_i = 1'b0;
    tick();

    // No hits: one clear, full scan, done at 2*64+2 cycles.
    c0 = clr_cnt; v0 = valid_cnt; base = pushes.size();
    do_start(8'd10);
    chk("nohit_clear", 144'(chain_clear_o), 144'd1);
    chk("nohit_busy", 144'(busy_o), 144'd1);
    wait_done(400, n);
    chk("nohit_latency", 144'(n), 144'd130);
    chk("nohit_last_addr", 144'(oam_addr_o), 144'd63);
    chk("nohit_clear_cnt", 144'(clr_cnt - c0), 144'd1);
    chk("nohit_valid_cnt", 144'(valid_cnt - v0), 144'd0);
    chk("nohit_pushes", 144'(pushes.size() - base), 144'd0);
    tick();
    chk("nohit_idle_busy", 144'(busy_o), 144'd0);

    // Two hits in index order, r=7 and r=4.
    y_m[3] = 8'd5; h_m[3] = 2'd0;
    y_m[7] = 8'd8; h_m[7] = 2'd1;
    base = pushes.size();
    do_start(8'd12);
    wait_done(400, n);
    chk("two_latency", 144'(n), 144'd134);
    chk("two_count", 144'(pushes.size() - base), 144'd2);
    if (pushes.size() >= base + 2) begin
      chk("two_push0", pushes[base], exp_out(3, 11'h067));
      chk("two_push1", pushes[base+1], exp_out(7, 11'h0E4));
      chk("two_pa0", 144'(pa_log[base]), 144'h067);
      chk("two_pa1", 144'(pa_log[base+1]), 144'h0E4);
    end
    tick();

    // Vertical mirror on a 32-row sprite.
    set_all_miss();
    y_m[2] = 8'd0; h_m[2] = 2'd3; mir_m[2] = 1'b1;
    base = pushes.size();
    do_start(8'd0);
    wait_done(400, n);
    chk("mir_count", 144'(pushes.size() - base), 144'd1);
    if (pushes.size() > base) begin
      chk("mir_pa", 144'(pa_log[base]), 144'h05F);
      chk("mir_push", pushes[base], exp_out(2, 11'h05F));
    end
    tick();
    base = pushes.size();
    do_start(8'd32);
    wait_done(400, n);
    chk("mir_row32_miss", 144'(pushes.size() - base), 144'd0);
    tick();

    // Overflow: 20 hits, only 16 units.
    set_all_miss();
    for (int i = 0; i < 20; i++) y_m[i] = 8'd50;
    base = pushes.size();
    do_start(8'd50);
    wait_done(400, n);
    chk("ovf_latency", 144'(n), 144'd68);
    chk("ovf_flag_done", 144'(overflow_o), 144'd1);
    chk("ovf_stop_addr", 144'(oam_addr_o), 144'd16);
    chk("ovf_count", 144'(pushes.size() - base), 144'd16);
    if (pushes.size() >= base + 16) begin
      chk("ovf_first", pushes[base], exp_out(0, 11'h000));
      chk("ovf_last", pushes[base+15], exp_out(15, 11'h1E0));
    end
    tick();
    chk("ovf_held", 144'(overflow_o), 144'd1);
    chk("ovf_idle", 144'(busy_o), 144'd0);

    // Back-pressure: ack held low 5 cycles on the push.
    set_all_miss();
    y_m[4] = 8'd20;
    out_ack_i = 1'b0;
    base = pushes.size();
    do_start(8'd20);
    chk("bp_ovf_cleared", 144'(overflow_o), 144'd0);
    k = 0;
    while (!out_valid_o && k < 200) begin tick(); k++; end
    chk("bp_valid_seen", 144'(out_valid_o), 144'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_out", out_o, exp_out(4, 11'h080));
      chk("bp_hold_valid", 144'(out_valid_o), 144'd1);
      chk("bp_hold_addr", 144'(oam_addr_o), 144'd4);
      tick();
    end
    out_ack_i = 1'b1;
    tick();
    chk("bp_valid_drop", 144'(out_valid_o), 144'd0);
    wait_done(400, n);
    chk("bp_count", 144'(pushes.size() - base), 144'd1);
    tick();

    // Abort during PUSH, then reset mid-scan.
    out_ack_i = 1'b0;
    do_start(8'd20);
    k = 0;
    while (!out_valid_o && k < 200) begin tick(); k++; end
    chk("abort_in_push", 144'(out_valid_o), 144'd1);
    d0 = done_cnt; c0 = clr_cnt;
    do_start(8'd10);
    chk("abort_clear", 144'(chain_clear_o), 144'd1);
    chk("abort_valid_drop", 144'(out_valid_o), 144'd0);
    chk("abort_busy", 144'(busy_o), 144'd1);
    repeat (20) tick();
    chk("abort_rescan_addr", 144'(oam_addr_o), 144'd9);
    chk("abort_no_done", 144'(done_cnt - d0), 144'd0);
    chk("abort_clear_cnt", 144'(clr_cnt - c0), 144'd1);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk_zero("midreset");
    tick();
    rst_i = 1'b0;
    out_ack_i = 1'b1;
    repeat (3) tick();
    chk("midreset_no_done", 144'(done_cnt - d0), 144'd0);
    chk("midreset_idle", 144'(busy_o), 144'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
